// File: rtl/doodle_pkg.sv
// Screen/block geometry defaults and the collision-scan FSM state type.
// Shared by the scanner top and its hit-check datapath; holds no logic.
package doodle_pkg;

   localparam int DEF_SCREEN_WIDTH  = 400;
   localparam int DEF_SCREEN_HEIGHT = 700;
   localparam int DEF_BLOCK_WIDTH   = 40;
   localparam int DEF_BLOCK_HEIGHT  = 5;
   localparam int DEF_DOODLE_WIDTH  = 20;

   localparam int DEF_BLOCK_IN_WIDTH  = DEF_SCREEN_WIDTH / DEF_BLOCK_WIDTH;
   localparam int DEF_BLOCK_IN_HEIGHT = DEF_SCREEN_HEIGHT / DEF_BLOCK_HEIGHT;
   localparam int DEF_COUNT_BLOCKS    = DEF_BLOCK_IN_WIDTH * DEF_BLOCK_IN_HEIGHT;
   localparam int DEF_IDX_W           = $clog2(DEF_COUNT_BLOCKS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HIT  = 2'd2,
      MISS = 2'd3
   } scan_state_t;

endpackage

// File: rtl/block_hit_check.sv
// Combinational landing test of the latched doodle feet against one block entry.
// Zero latency; 33-bit sums so edge comparisons near 2^32 never wrap.
module block_hit_check #(
   parameter int BLOCK_WIDTH  = 40,
   parameter int BLOCK_HEIGHT = 5,
   parameter int DOODLE_WIDTH = 20
) (
   input  logic [31:0] doodle_x,
   input  logic [31:0] doodle_y,
   input  logic        falling,
   input  logic [31:0] block_x,
   input  logic [31:0] block_y,
   input  logic        block_active,
   output logic        hit
);

   logic [32:0] feet_right;
   logic [32:0] block_right;
   logic [32:0] block_bottom;
   logic        x_overlap;
   logic        y_overlap;

   assign feet_right   = {1'b0, doodle_x} + 33'(DOODLE_WIDTH);
   assign block_right  = {1'b0, block_x} + 33'(BLOCK_WIDTH);
   assign block_bottom = {1'b0, block_y} + 33'(BLOCK_HEIGHT);

   // Touching edges (feet right edge == block left edge) is not a landing.
   assign x_overlap = (feet_right > {1'b0, block_x}) && ({1'b0, doodle_x} < block_right);
   assign y_overlap = (block_y <= doodle_y) && ({1'b0, doodle_y} <= block_bottom);

   assign hit = block_active && falling && x_overlap && y_overlap;

endmodule

// File: rtl/block_collision_scanner.sv
// Per-frame scan of the block table (one entry per cycle) reporting the first landing block.
// Hit at index k reported k+2 cycles after start; full miss at COUNT_BLOCKS+1; start while busy is dropped.
module block_collision_scanner
   import doodle_pkg::*;
#(
   parameter int SCREEN_WIDTH     = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT    = DEF_SCREEN_HEIGHT,
   parameter int BLOCK_WIDTH      = DEF_BLOCK_WIDTH,
   parameter int BLOCK_HEIGHT     = DEF_BLOCK_HEIGHT,
   parameter int DOODLE_WIDTH     = DEF_DOODLE_WIDTH,
   localparam int BLOCK_IN_WIDTH  = SCREEN_WIDTH / BLOCK_WIDTH,
   localparam int BLOCK_IN_HEIGHT = SCREEN_HEIGHT / BLOCK_HEIGHT,
   localparam int COUNT_BLOCKS    = BLOCK_IN_WIDTH * BLOCK_IN_HEIGHT,
   localparam int IDX_W           = $clog2(COUNT_BLOCKS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      doodleX,
   input  logic [31:0]      doodleY,
   input  logic             falling,
   input  logic             newView,
   output logic [IDX_W-1:0] blockIndex,
   input  logic [31:0]      blockX,
   input  logic [31:0]      blockY,
   input  logic             blockActive,
   output logic [31:0]      collisionX,
   output logic [31:0]      collisionY,
   output logic             hasCollide,
   output logic             busy,
   output logic             done
);

   localparam int ROW_W = (BLOCK_IN_HEIGHT > 1) ? $clog2(BLOCK_IN_HEIGHT) : 1;
   localparam int COL_W = (BLOCK_IN_WIDTH > 1) ? $clog2(BLOCK_IN_WIDTH) : 1;

   scan_state_t      state_q;
   scan_state_t      state_d;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      lat_x_q;
   logic [31:0]      lat_y_q;
   logic             lat_falling_q;
   logic [COL_W-1:0] coll_col_q;
   logic [ROW_W-1:0] coll_row_q;

   logic             entry_hit;
   logic             last_entry;
   logic             clear_cnt;
   logic             advance_cnt;
   logic             load_hit;
   logic             accept_start;

   block_hit_check #(
      .BLOCK_WIDTH  (BLOCK_WIDTH),
      .BLOCK_HEIGHT (BLOCK_HEIGHT),
      .DOODLE_WIDTH (DOODLE_WIDTH)
   ) u_hit_check (
      .doodle_x     (lat_x_q),
      .doodle_y     (lat_y_q),
      .falling      (lat_falling_q),
      .block_x      (blockX),
      .block_y      (blockY),
      .block_active (blockActive),
      .hit          (entry_hit)
   );

   assign last_entry   = (idx_q == IDX_W'(COUNT_BLOCKS - 1));
   assign accept_start = (state_q == IDLE) && start;

   always_comb begin
      state_d     = state_q;
      clear_cnt   = 1'b0;
      advance_cnt = 1'b0;
      load_hit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SCAN;
               clear_cnt = 1'b1;
            end
         end
         SCAN: begin
            // A table refresh invalidates everything already walked, including a same-cycle hit.
            if (newView) begin
               clear_cnt = 1'b1;
            end else if (entry_hit) begin
               state_d  = HIT;
               load_hit = 1'b1;
            end else if (last_entry) begin
               state_d = MISS;
            end else begin
               advance_cnt = 1'b1;
            end
         end
         HIT:     state_d = IDLE;
         MISS:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         row_q         <= '0;
         col_q         <= '0;
         idx_q         <= '0;
         lat_x_q       <= '0;
         lat_y_q       <= '0;
         lat_falling_q <= 1'b0;
         coll_col_q    <= '0;
         coll_row_q    <= '0;
      end else begin
         state_q <= state_d;
         if (clear_cnt) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
         end else if (advance_cnt) begin
            idx_q <= idx_q + IDX_W'(1);
            if (row_q == ROW_W'(BLOCK_IN_HEIGHT - 1)) begin
               row_q <= '0;
               col_q <= col_q + COL_W'(1);
            end else begin
               row_q <= row_q + ROW_W'(1);
            end
         end
         if (accept_start) begin
            lat_x_q       <= doodleX;
            lat_y_q       <= doodleY;
            lat_falling_q <= falling;
         end
         if (load_hit) begin
            coll_col_q <= col_q;
            coll_row_q <= row_q;
         end
      end
   end

   assign blockIndex = idx_q;
   assign collisionX = 32'(coll_col_q);
   assign collisionY = 32'(coll_row_q);
   assign hasCollide = (state_q == HIT);
   assign done       = (state_q == HIT) || (state_q == MISS);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_block_collision_scanner.sv
// Directed bench for block_collision_scanner with a behavioural block table and a result scoreboard.
// Cycle numbering: cycle 0 is the cycle in which start (or a restart) is sampled.
module tb_block_collision_scanner;

   localparam int NCOL   = 10;
   localparam int NROW   = 140;
   localparam int NBLK   = NCOL * NROW;
   localparam int IDXW   = $clog2(NBLK);
   localparam int BUDGET = 3000;

   typedef struct {
      int          lat;
      logic        hit;
      logic [31:0] cx;
      logic [31:0] cy;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            start;
   logic [31:0]     doodleX;
   logic [31:0]     doodleY;
   logic            falling;
   logic            newView;
   logic [IDXW-1:0] blockIndex;
   logic [31:0]     blockX;
   logic [31:0]     blockY;
   logic            blockActive;
   logic [31:0]     collisionX;
   logic [31:0]     collisionY;
   logic            hasCollide;
   logic            busy;
   logic            done;

   logic [31:0] tbl_x [NBLK];
   logic [31:0] tbl_y [NBLK];
   logic        tbl_a [NBLK];

   exp_t        sb [$];
   int          n_vec;
   int          n_bad;
   logic [31:0] m_cx;
   logic [31:0] m_cy;

   block_collision_scanner dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .doodleX     (doodleX),
      .doodleY     (doodleY),
      .falling     (falling),
      .newView     (newView),
      .blockIndex  (blockIndex),
      .blockX      (blockX),
      .blockY      (blockY),
      .blockActive (blockActive),
      .collisionX  (collisionX),
      .collisionY  (collisionY),
      .hasCollide  (hasCollide),
      .busy        (busy),
      .done        (done)
   );

   assign blockX      = tbl_x[blockIndex];
   assign blockY      = tbl_y[blockIndex];
   assign blockActive = tbl_a[blockIndex];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_table();
      for (int i = 0; i < NBLK; i++) begin
         tbl_x[i] = 32'd0;
         tbl_y[i] = 32'd0;
         tbl_a[i] = 1'b0;
      end
   endtask

   task automatic set_block(input int idx, input logic [31:0] x, input logic [31:0] y);
      tbl_x[idx] = x;
      tbl_y[idx] = y;
      tbl_a[idx] = 1'b1;
   endtask

   // Reference: first active entry the falling feet land on, counted from the last (re)start.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic f, input int offset);
      exp_t e;
      e.hit = 1'b0;
      e.lat = offset + NBLK + 1;
      e.cx  = m_cx;
      e.cy  = m_cy;
      if (f) begin
         for (int k = 0; k < NBLK; k++) begin
            if (tbl_a[k] &&
                ({1'b0, x} + 33'd20 > {1'b0, tbl_x[k]}) &&
                ({1'b0, x} < {1'b0, tbl_x[k]} + 33'd40) &&
                ({1'b0, tbl_y[k]} <= {1'b0, y}) &&
                ({1'b0, y} <= {1'b0, tbl_y[k]} + 33'd5)) begin
               e.hit = 1'b1;
               e.lat = offset + k + 2;
               e.cx  = k / NROW;
               e.cy  = k % NROW;
               break;
            end
         end
      end
      return e;
   endfunction

   // nv_cyc: cycle carrying a newView pulse (-1 none); st_cyc: cycle of a stray start (-1 none).
   task automatic run_scan(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic f, input int nv_cyc, input int st_cyc);
      exp_t e;
      exp_t got;
      bit   seen;
      e = model(x, y, f, (nv_cyc > 0) ? nv_cyc : 0);
      sb.push_back(e);
      doodleX = x;
      doodleY = y;
      falling = f;
      start   = 1'b1;
      newView = (nv_cyc == 0);
      seen    = 1'b0;
      for (int c = 1; c <= BUDGET && !seen; c++) begin
         @(negedge clk);
         if (c == 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
         if (done) begin
            got = sb.pop_front();
            check({tag, "_latency"}, c, got.lat);
            check({tag, "_hasCollide"}, 32'(hasCollide), 32'(got.hit));
            check({tag, "_collisionX"}, collisionX, got.cx);
            check({tag, "_collisionY"}, collisionY, got.cy);
            seen = 1'b1;
         end
         start   = (c == st_cyc);
         newView = (c == nv_cyc);
         if (seen) begin
            start   = 1'b0;
            newView = 1'b0;
         end
      end
      if (!seen) begin
         void'(sb.pop_front());
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end
      @(negedge clk);
      check({tag, "_done_after"}, {30'd0, done, busy}, 32'd0);
      m_cx = e.cx;
      m_cy = e.cy;
   endtask

   initial begin
      bit stray_done;
      n_vec   = 0;
      n_bad   = 0;
      m_cx    = 32'd0;
      m_cy    = 32'd0;
      reset   = 1'b1;
      start   = 1'b0;
      newView = 1'b0;
      doodleX = 32'd0;
      doodleY = 32'd0;
      falling = 1'b0;
      clear_table();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_hasCollide", 32'(hasCollide), 32'd0);
      check("rst_blockIndex", 32'(blockIndex), 32'd0);
      check("rst_collisionX", collisionX, 32'd0);
      check("rst_collisionY", collisionY, 32'd0);

      set_block(2, 32'd0, 32'd10);
      run_scan("basic_hit", 32'd5, 32'd12, 1'b1, -1, -1);
      run_scan("not_falling", 32'd5, 32'd12, 1'b0, -1, 10);
      run_scan("start_and_nv", 32'd5, 32'd12, 1'b1, 0, -1);

      set_block(3, 32'd0, 32'd10);
      run_scan("first_wins", 32'd5, 32'd12, 1'b1, -1, -1);

      clear_table();
      set_block(5 * NROW + 7, 32'd40, 32'd10);
      run_scan("edge_touch", 32'd20, 32'd12, 1'b1, -1, -1);
      run_scan("edge_overlap", 32'd21, 32'd12, 1'b1, -1, -1);
      run_scan("y_bottom", 32'd21, 32'd15, 1'b1, -1, -1);
      run_scan("y_below", 32'd21, 32'd16, 1'b1, -1, -1);

      clear_table();
      set_block(2, 32'd0, 32'd10);
      run_scan("newview_restart", 32'd5, 32'd12, 1'b1, 3, -1);

      doodleX = 32'd5;
      doodleY = 32'd12;
      falling = 1'b0;
      start   = 1'b1;
      for (int c = 1; c <= 500; c++) begin
         @(negedge clk);
         start = 1'b0;
         reset = (c == 500);
      end
      @(negedge clk);
      reset = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_hasCollide", 32'(hasCollide), 32'd0);
      check("midrst_blockIndex", 32'(blockIndex), 32'd0);
      check("midrst_collisionX", collisionX, 32'd0);
      check("midrst_collisionY", collisionY, 32'd0);
      stray_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done || busy) stray_done = 1'b1;
      end
      check("midrst_quiet", 32'(stray_done), 32'd0);
      m_cx = 32'd0;
      m_cy = 32'd0;
      run_scan("after_reset", 32'd5, 32'd12, 1'b1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
